uart_alu_ctrl: RTL and testbench

Multi-byte, frame-based command controller between the UART receiver/transmitter pair and the combinational ALU. It is the parametrised successor to the 8-bit single-byte operand interface. Operands are N_BITS wide and are assembled from several UART bytes, LSB first. A stalled frame is aborted by an inter-byte timeout. The N_BITS result is returned as a byte stream over the transmitter handshake.

---
 rtl/uart_alu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Frame-based UART command controller for the combinational ALU: assembles
// LSB-first N_BITS operands plus an opcode, then streams the result back bytewise.
//
// state     | meaning
// S_IDLE    | waiting for the first byte of a frame (stored as A byte 0)
// S_RX_A    | collecting remaining operand A bytes
// S_RX_B    | collecting operand B bytes
// S_RX_OP   | waiting for the opcode byte; commits A/B/op to the ALU
// S_EXEC    | one settle cycle, then result captured
// S_TX_SEND | loads next result byte and raises o_tx_start
// S_TX_WAIT | waiting for the transmitter to finish the current byte
module uart_alu_ctrl #(
    parameter int N_BITS  = 16,
    parameter int OP_BITS = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_done,
    input  logic [N_BITS-1:0] i_alu_result,
    output logic [N_BITS-1:0] o_dato_A,
    output logic [N_BITS-1:0] o_dato_B,
    output logic [OP_BITS-1:0] o_op,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int NBYTES = N_BITS / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_RX_OP,
        S_EXEC,
        S_TX_SEND,
        S_TX_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [N_BITS-1:0] shadow_a_q, shadow_b_q, result_sr_q;
    logic              tx_start_q, frame_err_q;
    logic [7:0]        tx_data_q;

    logic in_rx, rx_accept, tmr_zero, timed_out, last_rx_byte;

    assign in_rx        = (state_q == S_RX_A) || (state_q == S_RX_B) || (state_q == S_RX_OP);
    assign rx_accept    = i_rx_done && ((state_q == S_IDLE) || in_rx);
    assign tmr_zero     = (TIMEOUT != 0) && (tmr_q == '0);
    assign last_rx_byte = (byte_cnt_q == LAST_BYTE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        timed_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rx_done) state_d = (NBYTES == 1) ? S_RX_B : S_RX_A;
            end
            S_RX_A: begin
                if (i_rx_done) begin
                    if (last_rx_byte) state_d = S_RX_B;
                end else if (tmr_zero) begin
                    state_d   = S_IDLE;
                    timed_out = 1'b1;
                end
            end
            S_RX_B: begin
                if (i_rx_done) begin
                    if (last_rx_byte) state_d = S_RX_OP;
                end else if (tmr_zero) begin
                    state_d   = S_IDLE;
                    timed_out = 1'b1;
                end
            end
            S_RX_OP: begin
                if (i_rx_done) begin
                    state_d = S_EXEC;
                end else if (tmr_zero) begin
                    state_d   = S_IDLE;
                    timed_out = 1'b1;
                end
            end
            S_EXEC:    state_d = S_TX_SEND;
            S_TX_SEND: state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (i_tx_done) state_d = (tx_cnt_q == LAST_BYTE) ? S_IDLE : S_TX_SEND;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt_q  <= '0;
            tx_cnt_q    <= '0;
            tmr_q       <= '0;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            result_sr_q <= '0;
            o_dato_A    <= '0;
            o_dato_B    <= '0;
            o_op        <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= timed_out;
            tx_start_q  <= 1'b0;

            if (rx_accept)                  tmr_q <= TMR_LOAD;
            else if (in_rx && tmr_q != '0)  tmr_q <= tmr_q - TMR_W'(1);
            else if (!in_rx)                tmr_q <= '0;

            case (state_q)
                // byte_cnt is always 0 in IDLE, so the first byte lands in A byte 0
                S_IDLE, S_RX_A: begin
                    if (i_rx_done) begin
                        for (int k = 0; k < NBYTES; k++)
                            if (byte_cnt_q == CNT_W'(k)) shadow_a_q[8*k +: 8] <= i_rx_data;
                        byte_cnt_q <= last_rx_byte ? '0 : byte_cnt_q + CNT_W'(1);
                    end
                end
                S_RX_B: begin
                    if (i_rx_done) begin
                        for (int k = 0; k < NBYTES; k++)
                            if (byte_cnt_q == CNT_W'(k)) shadow_b_q[8*k +: 8] <= i_rx_data;
                        byte_cnt_q <= last_rx_byte ? '0 : byte_cnt_q + CNT_W'(1);
                    end
                end
                S_RX_OP: begin
                    if (i_rx_done) begin
                        o_dato_A   <= shadow_a_q;
                        o_dato_B   <= shadow_b_q;
                        o_op       <= i_rx_data[OP_BITS-1:0];
                        shadow_a_q <= '0;
                        shadow_b_q <= '0;
                    end
                end
                S_EXEC: begin
                    result_sr_q <= i_alu_result;
                    tx_cnt_q    <= '0;
                end
                S_TX_SEND: begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= result_sr_q[7:0];
                end
                S_TX_WAIT: begin
                    if (i_tx_done) begin
                        result_sr_q <= result_sr_q >> 8;
                        tx_cnt_q    <= (tx_cnt_q == LAST_BYTE) ? '0 : tx_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (timed_out) begin
                shadow_a_q <= '0;
                shadow_b_q <= '0;
                byte_cnt_q <= '0;
            end
        end
    end

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomised frame-level bench for uart_alu_ctrl with a behavioural ALU stub and
// a byte-stream reference model (operands, result bytes, error pulse count).
module tb_uart_alu_ctrl;

    localparam int N_BITS  = 16;
    localparam int OP_BITS = 6;
    localparam int TIMEOUT = 50;
    localparam int NB      = N_BITS / 8;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_rx_done = 1'b0;
    logic [7:0]         i_rx_data = '0;
    logic               i_tx_done = 1'b0;
    logic [N_BITS-1:0]  i_alu_result;
    logic [N_BITS-1:0]  o_dato_A, o_dato_B;
    logic [OP_BITS-1:0] o_op;
    logic               o_tx_start, o_busy, o_frame_err;
    logic [7:0]         o_tx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int exp_err = 0;

    logic [N_BITS-1:0]  m_a = '0, m_b = '0;
    logic [OP_BITS-1:0] m_op = '0;

    logic [5:0] op_list [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    uart_alu_ctrl #(.N_BITS(N_BITS), .OP_BITS(OP_BITS), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_dato_A     (o_dato_A),
        .o_dato_B     (o_dato_B),
        .o_op         (o_op),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [N_BITS-1:0] alu_f(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b,
                                                input logic [OP_BITS-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[3:0];
            6'h03:   return N_BITS'($signed(a) >>> b[3:0]);
            default: return '0;
        endcase
    endfunction

    assign i_alu_result = alu_f(o_dato_A, o_dato_B, o_op);

    always @(negedge i_clk) if (o_frame_err) err_pulses++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that samples the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge i_clk); #1; end
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge i_clk); #1;
        i_rx_done = 1'b0;
        i_rx_data = $urandom_range(0, 255);
    endtask

    task automatic send_frame(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b,
                              input logic [7:0] opb, input int long_idx);
        logic [7:0] fb [2*NB+1];
        for (int k = 0; k < NB; k++) begin
            fb[k]      = a[8*k +: 8];
            fb[NB + k] = b[8*k +: 8];
        end
        fb[2*NB] = opb;
        for (int i = 0; i < 2*NB+1; i++)
            send_byte(fb[i], (i == long_idx) ? TIMEOUT : int'($urandom_range(0, 4)));
        m_a  = a;
        m_b  = b;
        m_op = opb[OP_BITS-1:0];
        check_val("dato_a", o_dato_A, m_a);
        check_val("dato_b", o_dato_B, m_b);
        check_val("op", o_op, m_op);
        check_val("busy_exec", o_busy, 1);
    endtask

    task automatic recv_result(input bit inject);
        logic [N_BITS-1:0] res;
        int d;
        res = alu_f(m_a, m_b, m_op);
        @(posedge i_clk); #1;
        check_val("tx_start_exec", o_tx_start, 0);
        @(posedge i_clk); #1;
        for (int k = 0; k < NB; k++) begin
            check_val("tx_start", o_tx_start, 1);
            check_val("tx_byte", o_tx_data, res[8*k +: 8]);
            d = $urandom_range(1, 4);
            for (int j = 0; j < d; j++) begin
                if (inject && $urandom_range(0, 1) == 1) begin
                    i_rx_done = 1'b1;
                    i_rx_data = $urandom_range(0, 255);
                end
                @(posedge i_clk); #1;
                i_rx_done = 1'b0;
                if (j == 0) check_val("tx_start_pulse", o_tx_start, 0);
            end
            check_val("tx_data_stable", o_tx_data, res[8*k +: 8]);
            i_tx_done = 1'b1;
            @(posedge i_clk); #1;
            i_tx_done = 1'b0;
            @(posedge i_clk); #1;
            if (k == NB-1) check_val("busy_done", o_busy, 0);
        end
    endtask

    initial begin
        bit no_err;

        repeat (3) @(posedge i_clk);
        #1;
        check_val("rst_dato_a", o_dato_A, 0);
        check_val("rst_dato_b", o_dato_B, 0);
        check_val("rst_op", o_op, 0);
        check_val("rst_tx_start", o_tx_start, 0);
        check_val("rst_tx_data", o_tx_data, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_frame_err", o_frame_err, 0);
        @(negedge i_clk) i_reset = 1'b1;
        @(posedge i_clk); #1;

        send_frame(16'h1234, 16'h0011, 8'h20, -1);
        check_val("dir_dato_a", o_dato_A, 16'h1234);
        check_val("dir_result", i_alu_result, 16'h1245);
        recv_result(1'b0);

        // stalled frame: only A arrives, then the line goes quiet
        send_byte(8'h34, 0);
        send_byte(8'h12, 2);
        no_err = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(posedge i_clk); #1;
            if (o_frame_err !== 1'b0 || o_busy !== 1'b1) no_err = 1'b0;
        end
        check_val("to_early", no_err, 1);
        @(posedge i_clk); #1;
        exp_err++;
        check_val("to_pulse", o_frame_err, 1);
        check_val("to_idle", o_busy, 0);
        check_val("to_keep_a", o_dato_A, m_a);
        check_val("to_keep_op", o_op, m_op);
        @(posedge i_clk); #1;
        check_val("to_single", o_frame_err, 0);
        send_frame(16'hBEEF, 16'h0102, 8'h22, -1);
        recv_result(1'b0);

        // byte arrives exactly on the expiry cycle
        send_frame(N_BITS'($urandom), N_BITS'($urandom), {2'($urandom), op_list[$urandom_range(0, 7)]}, 2);
        recv_result(1'b0);

        for (int n = 0; n < 20; n++) begin
            send_frame(N_BITS'($urandom), N_BITS'($urandom), {2'($urandom), op_list[$urandom_range(0, 7)]}, -1);
            recv_result(1'b1);
        end

        // asynchronous reset in the middle of a transmission
        send_frame(16'hA5C3, 16'h0F0F, 8'h26, -1);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #2;
        i_reset = 1'b0;
        #1;
        check_val("arst_dato_a", o_dato_A, 0);
        check_val("arst_dato_b", o_dato_B, 0);
        check_val("arst_op", o_op, 0);
        check_val("arst_tx_data", o_tx_data, 0);
        check_val("arst_tx_start", o_tx_start, 0);
        check_val("arst_busy", o_busy, 0);
        m_a  = '0;
        m_b  = '0;
        m_op = '0;
        @(negedge i_clk) i_reset = 1'b1;
        @(posedge i_clk); #1;
        send_frame(16'h7FFF, 16'h0001, 8'h20, -1);
        recv_result(1'b0);

        repeat (2) @(posedge i_clk);
        #1;
        check_val("err_pulses", err_pulses, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
